// File: rtl/txs_burst_arbiter_if.sv
// Requester-side burst handshake plus the Avalon-MM write-burst master bus.
// "slave" is the arbiter's view; "master" is the requester/host side driving it.
interface txs_burst_arbiter_if;
  logic [1:0]   rq_req;
  logic [22:0]  rq0_addr, rq1_addr;
  logic [5:0]   rq0_len, rq1_len;
  logic [1:0]   rq_eof;
  logic [127:0] rq0_d, rq1_d;
  logic [1:0]   rq_dv;
  logic [1:0]   rq_gnt;
  logic [1:0]   rq_drdy;
  logic         txs_write;
  logic [22:0]  txs_address;
  logic [5:0]   txs_burstcount;
  logic [127:0] txs_writedata;
  logic         txs_waitrequest;

  modport slave (
    input  rq_req, rq0_addr, rq1_addr, rq0_len, rq1_len, rq_eof, rq0_d, rq1_d, rq_dv,
           txs_waitrequest,
    output rq_gnt, rq_drdy, txs_write, txs_address, txs_burstcount, txs_writedata
  );

  modport master (
    output rq_req, rq0_addr, rq1_addr, rq0_len, rq1_len, rq_eof, rq0_d, rq1_d, rq_dv,
           txs_waitrequest,
    input  rq_gnt, rq_drdy, txs_write, txs_address, txs_burstcount, txs_writedata
  );
endinterface

// File: rtl/txs_burst_arbiter.sv
// Two-requester round-robin arbiter feeding camera DMA bursts onto one Avalon write master.
// Illegal lengths are granted (to unblock the requester) but flagged in err and never issued.
module txs_burst_arbiter #(
  parameter int MAX_BURST = 32
) (
  input  logic              c,
  input  logic              rst,
  input  logic              en,
  txs_burst_arbiter_if.slave bus,
  output logic [1:0]        irq,
  input  logic [1:0]        irq_clr,
  output logic [1:0]        err,
  output logic              busy
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [6:0] MAXB = 7'(MAX_BURST);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [22:0] addr_q, addr_d;
  logic [5:0]  len_q, len_d;
  logic        eof_q, eof_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  irq_q, irq_d;
  logic [1:0]  err_q, err_d;

  logic [1:0]  gnt, drdy, irq_set;
  logic        write, pick, dv, accept;
  logic [5:0]  sel_len;

  // Tie goes to whoever was not granted last; last_q resets to 1 so requester 0 wins first.
  assign pick    = (&bus.rq_req) ? ~last_q : bus.rq_req[1];
  assign sel_len = pick ? bus.rq1_len : bus.rq0_len;
  assign dv      = owner_q ? bus.rq_dv[1] : bus.rq_dv[0];
  assign accept  = write & ~bus.txs_waitrequest;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    len_d   = len_q;
    eof_d   = eof_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    gnt     = 2'b00;
    drdy    = 2'b00;
    write   = 1'b0;
    irq_set = 2'b00;
    case (state_q)
      IDLE: begin
        if (en && |bus.rq_req && !rst) begin
          gnt     = pick ? 2'b10 : 2'b01;
          owner_d = pick;
          last_d  = pick;
          addr_d  = pick ? bus.rq1_addr : bus.rq0_addr;
          len_d   = sel_len;
          eof_d   = pick ? bus.rq_eof[1] : bus.rq_eof[0];
          cnt_d   = 6'd0;
          if (sel_len == 6'd0 || {1'b0, sel_len} > MAXB)
            err_d = err_q | gnt;
          else
            state_d = BURST;
        end
      end
      BURST: begin
        write = dv & ~rst;
        if (accept) begin
          drdy  = owner_q ? 2'b10 : 2'b01;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q + 6'd1 == len_q) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
            if (eof_q) irq_set = drdy;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A set arriving with its clear keeps the bit: the new frame must not be lost.
    irq_d = (irq_q & ~irq_clr) | irq_set;
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      len_q   <= '0;
      eof_q   <= 1'b0;
      cnt_q   <= '0;
      irq_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      eof_q   <= eof_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
    end
  end

  assign bus.rq_gnt         = gnt;
  assign bus.rq_drdy        = drdy;
  assign bus.txs_write      = write;
  assign bus.txs_address    = addr_q;
  assign bus.txs_burstcount = len_q;
  assign bus.txs_writedata  = owner_q ? bus.rq1_d : bus.rq0_d;
  assign irq                = irq_q;
  assign err                = err_q;
  assign busy               = (state_q == BURST);

endmodule

// File: tb/tb_txs_burst_arbiter.sv
// Directed bench for txs_burst_arbiter: one task per scenario, hand-derived cycle tables.
module tb_txs_burst_arbiter;
  logic       c = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] irq_clr = 2'b00;
  logic [1:0] irq, err;
  logic       busy;
  int         total = 0;
  int         bad = 0;

  txs_burst_arbiter_if bus();

  txs_burst_arbiter #(.MAX_BURST(32)) dut (
    .c(c), .rst(rst), .en(en), .bus(bus.slave),
    .irq(irq), .irq_clr(irq_clr), .err(err), .busy(busy)
  );

  always #5 c = ~c;

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic clr_inputs();
    bus.rq_req = 2'b00; bus.rq0_addr = '0; bus.rq1_addr = '0;
    bus.rq0_len = '0; bus.rq1_len = '0; bus.rq_eof = 2'b00;
    bus.rq0_d = '0; bus.rq1_d = '0; bus.rq_dv = 2'b00;
    bus.txs_waitrequest = 1'b0; irq_clr = 2'b00; en = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    total++; if (irq !== 2'b00) begin bad++; $display("FAIL reset_irq got=%0h exp=0", irq); end
    total++; if (err !== 2'b00) begin bad++; $display("FAIL reset_err got=%0h exp=0", err); end
    total++; if (bus.txs_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%0h exp=0", bus.txs_write); end
    total++; if (bus.rq_gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%0h exp=0", bus.rq_gnt); end
    total++; if (bus.txs_address !== 23'h0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", bus.txs_address); end
    total++; if (bus.txs_burstcount !== 6'd0) begin bad++; $display("FAIL reset_bc got=%0h exp=0", bus.txs_burstcount); end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1; bus.rq_req = 2'b01; bus.rq0_addr = 23'h000100; bus.rq0_len = 6'd4;
    bus.rq_dv = 2'b11; bus.rq0_d = 128'hA0; bus.rq1_d = 128'hFF;
    #1;
    total++; if (bus.rq_gnt !== 2'b01) begin bad++; $display("FAIL single_gnt got=%0h exp=1", bus.rq_gnt); end
    total++; if (bus.txs_write !== 1'b0) begin bad++; $display("FAIL single_idle_write got=%0h exp=0", bus.txs_write); end
    tick();
    bus.rq_req = 2'b00;
    for (int b = 0; b < 4; b++) begin
      bus.rq0_d = 128'hA0 + 128'(b);
      #1;
      total++; if (bus.txs_write !== 1'b1) begin bad++; $display("FAIL single_write b%0d got=%0h exp=1", b, bus.txs_write); end
      total++; if (bus.txs_address !== 23'h000100) begin bad++; $display("FAIL single_addr b%0d got=%0h exp=100", b, bus.txs_address); end
      total++; if (bus.txs_burstcount !== 6'd4) begin bad++; $display("FAIL single_bc b%0d got=%0d exp=4", b, bus.txs_burstcount); end
      total++; if (bus.rq_drdy !== 2'b01) begin bad++; $display("FAIL single_drdy b%0d got=%0h exp=1", b, bus.rq_drdy); end
      total++; if (bus.rq_gnt !== 2'b00) begin bad++; $display("FAIL single_gnt_once b%0d got=%0h exp=0", b, bus.rq_gnt); end
      total++; if (bus.txs_writedata !== 128'hA0 + 128'(b)) begin bad++; $display("FAIL single_data b%0d got=%0h exp=%0h", b, bus.txs_writedata, 128'hA0 + 128'(b)); end
      tick();
    end
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_after got=%0h exp=0", busy); end
    total++; if (bus.txs_write !== 1'b0) begin bad++; $display("FAIL single_write_after got=%0h exp=0", bus.txs_write); end
  endtask

  task automatic test_contention();
    logic [1:0] eg [13] = '{2'b01,2'b00,2'b00,2'b10,2'b00,2'b00,2'b01,2'b00,2'b00,2'b10,2'b00,2'b00,2'b01};
    logic [1:0] ed [13] = '{2'b00,2'b01,2'b01,2'b00,2'b10,2'b10,2'b00,2'b01,2'b01,2'b00,2'b10,2'b10,2'b00};
    logic [127:0] exp_d;
    do_reset();
    en = 1'b1; bus.rq_req = 2'b11; bus.rq0_len = 6'd2; bus.rq1_len = 6'd2;
    bus.rq0_addr = 23'h10; bus.rq1_addr = 23'h20;
    bus.rq_dv = 2'b11; bus.rq0_d = 128'hAAAA; bus.rq1_d = 128'hBBBB;
    for (int i = 0; i < 13; i++) begin
      #1;
      total++; if (bus.rq_gnt !== eg[i]) begin bad++; $display("FAIL cont_gnt c%0d got=%0h exp=%0h", i, bus.rq_gnt, eg[i]); end
      total++; if (bus.rq_drdy !== ed[i]) begin bad++; $display("FAIL cont_drdy c%0d got=%0h exp=%0h", i, bus.rq_drdy, ed[i]); end
      total++; if (busy !== (ed[i] != 2'b00)) begin bad++; $display("FAIL cont_busy c%0d got=%0h exp=%0h", i, busy, (ed[i] != 2'b00)); end
      if (ed[i] != 2'b00) begin
        exp_d = (ed[i] == 2'b01) ? 128'hAAAA : 128'hBBBB;
        total++; if (bus.txs_writedata !== exp_d) begin bad++; $display("FAIL cont_data c%0d got=%0h exp=%0h", i, bus.txs_writedata, exp_d); end
      end
      tick();
    end
    bus.rq_req = 2'b00;
  endtask

  task automatic test_backpressure();
    logic w [7] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0};
    int k = 0;
    do_reset();
    en = 1'b1; bus.rq_req = 2'b01; bus.rq0_addr = 23'h2A0; bus.rq0_len = 6'd4; bus.rq_dv = 2'b01;
    bus.rq0_d = 128'hD0;
    tick();
    bus.rq_req = 2'b00;
    for (int j = 0; j < 7; j++) begin
      bus.txs_waitrequest = w[j];
      bus.rq0_d = 128'hD0 + 128'(k);
      #1;
      total++; if (bus.rq_drdy !== (w[j] ? 2'b00 : 2'b01)) begin bad++; $display("FAIL bp_drdy c%0d got=%0h exp=%0h", j, bus.rq_drdy, (w[j] ? 2'b00 : 2'b01)); end
      total++; if (bus.txs_writedata !== 128'hD0 + 128'(k)) begin bad++; $display("FAIL bp_data c%0d got=%0h exp=%0h", j, bus.txs_writedata, 128'hD0 + 128'(k)); end
      total++; if (bus.txs_address !== 23'h2A0) begin bad++; $display("FAIL bp_addr c%0d got=%0h exp=2a0", j, bus.txs_address); end
      if (bus.rq_drdy == 2'b01) k++;
      tick();
    end
    bus.txs_waitrequest = 1'b0;
    #1;
    total++; if (k !== 4) begin bad++; $display("FAIL bp_beats got=%0d exp=4", k); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%0h exp=0", busy); end
  endtask

  task automatic test_frame_end();
    do_reset();
    en = 1'b1; bus.rq_req = 2'b10; bus.rq1_addr = 23'h4000; bus.rq1_len = 6'd8;
    bus.rq_eof = 2'b10; bus.rq_dv = 2'b10;
    tick();
    bus.rq_req = 2'b00;
    for (int b = 0; b < 8; b++) begin
      #1;
      total++; if (irq !== 2'b00) begin bad++; $display("FAIL fe_irq_early b%0d got=%0h exp=0", b, irq); end
      tick();
    end
    total++; if (irq !== 2'b10) begin bad++; $display("FAIL fe_irq_set got=%0h exp=2", irq); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fe_idle got=%0h exp=0", busy); end
    tick();
    total++; if (irq !== 2'b10) begin bad++; $display("FAIL fe_irq_hold got=%0h exp=2", irq); end
    bus.rq_req = 2'b10; bus.rq1_len = 6'd1;
    tick();
    bus.rq_req = 2'b00; irq_clr = 2'b10;
    #1;
    total++; if (bus.rq_drdy !== 2'b10) begin bad++; $display("FAIL fe_last_beat got=%0h exp=2", bus.rq_drdy); end
    tick();
    irq_clr = 2'b00;
    total++; if (irq !== 2'b10) begin bad++; $display("FAIL fe_set_beats_clr got=%0h exp=2", irq); end
    irq_clr = 2'b10;
    tick();
    irq_clr = 2'b00;
    total++; if (irq !== 2'b00) begin bad++; $display("FAIL fe_clr got=%0h exp=0", irq); end
  endtask

  task automatic test_illegal();
    logic [5:0] lens [2] = '{6'd0, 6'd33};
    do_reset();
    en = 1'b1; bus.rq_dv = 2'b01;
    for (int t = 0; t < 2; t++) begin
      bus.rq_req = 2'b01; bus.rq0_len = lens[t];
      #1;
      total++; if (bus.rq_gnt !== 2'b01) begin bad++; $display("FAIL ill_gnt len%0d got=%0h exp=1", lens[t], bus.rq_gnt); end
      tick();
      bus.rq_req = 2'b00;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ill_busy len%0d got=%0h exp=0", lens[t], busy); end
      total++; if (bus.txs_write !== 1'b0) begin bad++; $display("FAIL ill_write len%0d got=%0h exp=0", lens[t], bus.txs_write); end
      total++; if (err !== 2'b01) begin bad++; $display("FAIL ill_err len%0d got=%0h exp=1", lens[t], err); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; bus.rq_req = 2'b01; bus.rq0_len = 6'd8; bus.rq_eof = 2'b01; bus.rq_dv = 2'b01;
    tick();
    bus.rq_req = 2'b00;
    for (int b = 0; b < 3; b++) tick();
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rm_busy_pre got=%0h exp=1", busy); end
    total++; if (err !== 2'b01) begin bad++; $display("FAIL rm_err_sticky got=%0h exp=1", err); end
    rst = 1'b1;
    tick();
    total++; if (bus.txs_write !== 1'b0) begin bad++; $display("FAIL rm_write got=%0h exp=0", bus.txs_write); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%0h exp=0", busy); end
    total++; if (irq !== 2'b00) begin bad++; $display("FAIL rm_irq got=%0h exp=0", irq); end
    total++; if (err !== 2'b00) begin bad++; $display("FAIL rm_err got=%0h exp=0", err); end
    rst = 1'b0; en = 1'b1; bus.rq_req = 2'b11; bus.rq1_len = 6'd2;
    #1;
    total++; if (bus.rq_gnt !== 2'b01) begin bad++; $display("FAIL rm_gnt got=%0h exp=1", bus.rq_gnt); end
    tick();
    bus.rq_req = 2'b00;
  endtask

  initial begin
    clr_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_frame_end();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/txs_burst_arbiter.md
TXS_BURST_ARBITER -- requirements
Module: txs_burst_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 32, maximum beats per Avalon write burst.
REQ-002 SHALL have port c  in  1  system clock (clk125 domain); all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port en  in  1  grant enable (host "start sending images").
REQ-005 SHALL have port rq_req  in  2  per-requester burst request (0 = cam 0 DMA, 1 = cam 1 DMA); held until rq_gnt.
REQ-006 SHALL have ports rq0_addr, rq1_addr  in  23 each  burst start address; rq0_len, rq1_len  in  6 each  beats; rq_eof  in  2  burst is last of frame; all sampled at grant.
REQ-007 SHALL have ports rq0_d, rq1_d  in  128 each  beat data; rq_dv  in  2  beat valid.
REQ-008 SHALL have port rq_gnt  out  2  one-cycle grant pulse; rq_drdy  out  2  beat accepted.
REQ-009 SHALL have ports txs_write  out  1; txs_address  out  23; txs_burstcount  out  6; txs_writedata  out  128; txs_waitrequest  in  1.
REQ-010 SHALL have ports irq  out  2  frame-done, level; irq_clr  in  2  clear; err  out  2  sticky illegal length; busy  out  1  burst in progress.

Function
REQ-011 SHALL implement FSM IDLE -> BURST -> IDLE; owner register selects requester during BURST.
REQ-012 In IDLE with en=1 and any rq_req, SHALL move to BURST next cycle, pulse rq_gnt[owner] that cycle, and register addr, len, eof of owner.
REQ-013 Both requesting SHALL grant the requester not granted last (round robin); after reset requester 0 wins the first tie.
REQ-014 en=0 SHALL block new grants only; a burst in progress SHALL complete.
REQ-015 In BURST, txs_address and txs_burstcount SHALL hold the registered values for the whole burst.
REQ-016 txs_write SHALL equal (state==BURST) & rq_dv[owner], combinationally; txs_writedata SHALL be owner's rq_d.
REQ-017 A beat SHALL be accepted when txs_write & ~txs_waitrequest; rq_drdy[owner] SHALL be high exactly in that cycle; non-owner rq_drdy SHALL be 0.
REQ-018 rq_dv low mid-burst SHALL drop txs_write without ending the burst; address/burstcount remain held.
REQ-019 6-bit beat counter SHALL increment per accepted beat; acceptance of beat len SHALL return FSM to IDLE next cycle (minimum one IDLE cycle between bursts).
REQ-020 rq_len of 0 or > MAX_BURST SHALL still be granted, SHALL set err[owner], SHALL produce no txs_write, and SHALL return to IDLE next cycle.
REQ-021 Final beat accepted with registered eof=1 SHALL set irq[owner] next cycle; irq bit SHALL hold until irq_clr bit.
REQ-022 Simultaneous irq set and irq_clr on same bit SHALL leave irq set.
REQ-023 err SHALL clear only on rst.
REQ-024 busy SHALL be 1 exactly while state==BURST.

Reset
REQ-025 rst=1 SHALL force IDLE, counter 0, round-robin pointer to favour requester 0, irq=0, err=0, rq_gnt=0, busy=0, txs_write=0, registered address/burstcount=0, even mid-burst; requesters are reset by the same rst.

Verification
REQ-026 Single burst: en=1, rq_req=01, rq0_addr=0x000100, len=4, dv always 1, waitrequest=0 -> rq_gnt=01 one cycle, 4 consecutive txs_write beats, address 0x000100, burstcount 4, IDLE after.
REQ-027 Contention: both request continuously, len=2, after reset -> grant order 0,1,0,1; one idle cycle between bursts; no beat interleaving.
REQ-028 Backpressure: waitrequest high for 3 cycles on beat 2 of 4 -> txs_writedata/address stable, rq_drdy low those cycles, exactly 4 accepted beats.
REQ-029 Frame end: rq1 burst len=8 eof=1 -> irq=10 cycle after beat 8; irq_clr=10 same cycle as a second eof completion -> irq stays 10; then irq_clr alone -> 00.
REQ-030 Illegal length: rq0_len=0, then len=33 -> err=01, zero txs_write, FSM back to IDLE one cycle after each grant.
REQ-031 Reset mid-burst: rst after beat 3 of 8 -> next cycle txs_write=0, busy=0, irq=0; en=1 with both requesting then grants requester 0.
